// File: rtl/bp_update_queue.sv
// rtl/bp_update_queue.sv - in-order branch record queue feeding gshare predictor updates
module bp_update_queue #(
    parameter int DEPTH = 8,
    parameter int IDX_W = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_valid,
    output logic                       push_ready,
    input  logic [IDX_W-1:0]           push_idx,
    input  logic [1:0]                 push_sc,
    input  logic                       push_taken,
    input  logic                       resolve_valid,
    input  logic                       resolve_taken,
    input  logic                       flush,
    output logic                       upd_br_inst,
    output logic                       upd_br_taken,
    output logic [IDX_W-1:0]           upd_idx,
    output logic [1:0]                 upd_sc,
    output logic                       mispredict,
    output logic                       resolve_err,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [IDX_W-1:0] mem_idx   [DEPTH];
    logic [1:0]       mem_sc    [DEPTH];
    logic             mem_taken [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    logic empty;
    logic full;
    logic do_pop;
    logic do_push;
    logic wrong_path;
    logic discard;

    assign empty      = (count == '0);
    assign full       = (count == CNT_W'(DEPTH));
    assign push_ready = !full;

    // A pop only happens with something to pop; a wrong prediction on it
    // kills every younger record, as does an external flush.
    assign do_pop     = resolve_valid && !empty;
    assign wrong_path = do_pop && (resolve_taken != mem_taken[head]);
    assign discard    = wrong_path || flush;
    assign do_push    = push_valid && push_ready && !discard;

    // Record storage; contents are don't-care after reset so it is left unreset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_idx[tail]   <= push_idx;
            mem_sc[tail]    <= push_sc;
            mem_taken[tail] <= push_taken;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (discard) begin
            // Nothing is pushed on a discard, so tail is already the new head.
            head  <= tail;
            count <= '0;
        end else begin
            if (do_pop) begin
                head <= head + PTR_W'(1);
            end
            if (do_push) begin
                tail <= tail + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Registered update port and status pulses, valid for one cycle after a resolve.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            upd_br_inst  <= 1'b0;
            upd_br_taken <= 1'b0;
            upd_idx      <= '0;
            upd_sc       <= '0;
            mispredict   <= 1'b0;
            resolve_err  <= 1'b0;
        end else begin
            upd_br_inst  <= do_pop;
            upd_br_taken <= do_pop && resolve_taken;
            upd_idx      <= do_pop ? mem_idx[head] : '0;
            upd_sc       <= do_pop ? mem_sc[head]  : '0;
            mispredict   <= wrong_path;
            resolve_err  <= resolve_valid && empty;
        end
    end

endmodule

// File: tb/tb_bp_update_queue.sv
// tb/tb_bp_update_queue.sv - directed self-checking bench for bp_update_queue
module tb_bp_update_queue;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       push_valid;
    logic       push_ready;
    logic [4:0] push_idx;
    logic [1:0] push_sc;
    logic       push_taken;
    logic       resolve_valid;
    logic       resolve_taken;
    logic       flush;
    logic       upd_br_inst;
    logic       upd_br_taken;
    logic [4:0] upd_idx;
    logic [1:0] upd_sc;
    logic       mispredict;
    logic       resolve_err;
    logic [3:0] count;

    int checks   = 0;
    int failures = 0;

    bp_update_queue #(.DEPTH(8), .IDX_W(5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .push_valid    (push_valid),
        .push_ready    (push_ready),
        .push_idx      (push_idx),
        .push_sc       (push_sc),
        .push_taken    (push_taken),
        .resolve_valid (resolve_valid),
        .resolve_taken (resolve_taken),
        .flush         (flush),
        .upd_br_inst   (upd_br_inst),
        .upd_br_taken  (upd_br_taken),
        .upd_idx       (upd_idx),
        .upd_sc        (upd_sc),
        .mispredict    (mispredict),
        .resolve_err   (resolve_err),
        .count         (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        push_valid    = 1'b0;
        push_idx      = '0;
        push_sc       = '0;
        push_taken    = 1'b0;
        resolve_valid = 1'b0;
        resolve_taken = 1'b0;
        flush         = 1'b0;
    endtask

    task automatic set_push(input int idx, input int sc, input bit tk);
        push_valid = 1'b1;
        push_idx   = 5'(idx);
        push_sc    = 2'(sc);
        push_taken = tk;
    endtask

    task automatic push_one(input int idx, input int sc, input bit tk);
        set_push(idx, sc, tk);
        step();
        idle_inputs();
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_inst"},  upd_br_inst,  0);
        check({tag, "_taken"}, upd_br_taken, 0);
        check({tag, "_idx"},   upd_idx,      0);
        check({tag, "_sc"},    upd_sc,       0);
        check({tag, "_mis"},   mispredict,   0);
        check({tag, "_err"},   resolve_err,  0);
        check({tag, "_cnt"},   count,        0);
        check({tag, "_rdy"},   push_ready,   1);
    endtask

    function automatic int wrap_idx(input int j);
        return (j * 7 + 1) & 31;
    endfunction

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        step();
        check_quiet("reset");
        rst_n = 1'b1;

        // In-order update stream with correct predictions.
        push_one(3, 1, 0);
        push_one(7, 2, 1);
        push_one(9, 3, 1);
        check("t1_cnt3", count, 3);
        resolve_valid = 1'b1; resolve_taken = 1'b0;
        step();
        check("t1_inst0", upd_br_inst, 1);
        check("t1_idx0", upd_idx, 3);
        check("t1_sc0", upd_sc, 1);
        check("t1_tk0", upd_br_taken, 0);
        check("t1_mis0", mispredict, 0);
        check("t1_cnt2", count, 2);
        resolve_taken = 1'b1;
        step();
        check("t1_inst1", upd_br_inst, 1);
        check("t1_idx1", upd_idx, 7);
        check("t1_sc1", upd_sc, 2);
        check("t1_tk1", upd_br_taken, 1);
        check("t1_mis1", mispredict, 0);
        step();
        check("t1_inst2", upd_br_inst, 1);
        check("t1_idx2", upd_idx, 9);
        check("t1_sc2", upd_sc, 3);
        check("t1_mis2", mispredict, 0);
        check("t1_cnt0", count, 0);
        idle_inputs();
        step();
        check("t1_inst_off", upd_br_inst, 0);

        // Fill to capacity; pushes while full are refused even with a pop.
        for (int i = 0; i < 8; i++) push_one(i + 16, i & 3, 1);
        check("t2_cnt8", count, 8);
        check("t2_rdy0", push_ready, 0);
        push_one(30, 0, 0);
        check("t2_cnt_9th", count, 8);
        set_push(31, 1, 0);
        resolve_valid = 1'b1; resolve_taken = 1'b1;
        step();
        idle_inputs();
        check("t2_full_pop_cnt", count, 7);
        check("t2_full_pop_idx", upd_idx, 16);
        check("t2_rdy1", push_ready, 1);
        flush = 1'b1;
        step();
        idle_inputs();
        check("t2_flush_cnt", count, 0);

        // Mispredict discards younger records and the concurrent push.
        push_one(10, 2, 0);
        push_one(11, 1, 1);
        push_one(12, 0, 1);
        push_one(13, 3, 0);
        set_push(20, 1, 1);
        resolve_valid = 1'b1; resolve_taken = 1'b1;
        step();
        idle_inputs();
        check("t3_mis", mispredict, 1);
        check("t3_tk", upd_br_taken, 1);
        check("t3_idx", upd_idx, 10);
        check("t3_sc", upd_sc, 2);
        check("t3_cnt", count, 0);
        step();
        check("t3_mis_off", mispredict, 0);
        check("t3_cnt_stay", count, 0);

        // Flush with a correct resolve still emits the update.
        push_one(5, 1, 1);
        push_one(6, 2, 0);
        flush = 1'b1; resolve_valid = 1'b1; resolve_taken = 1'b1;
        step();
        idle_inputs();
        check("t4_inst", upd_br_inst, 1);
        check("t4_idx", upd_idx, 5);
        check("t4_mis", mispredict, 0);
        check("t4_cnt", count, 0);

        // Resolve on empty with a concurrent push.
        set_push(15, 3, 0);
        resolve_valid = 1'b1; resolve_taken = 1'b0;
        step();
        idle_inputs();
        check("t5_err", resolve_err, 1);
        check("t5_inst", upd_br_inst, 0);
        check("t5_cnt", count, 1);
        resolve_valid = 1'b1; resolve_taken = 1'b0;
        step();
        idle_inputs();
        check("t5_err_off", resolve_err, 0);
        check("t5_inst2", upd_br_inst, 1);
        check("t5_idx2", upd_idx, 15);
        check("t5_sc2", upd_sc, 3);
        check("t5_mis2", mispredict, 0);
        check("t5_cnt0", count, 0);

        // Keep three records in flight while 20 push/pop pairs wrap the pointers.
        for (int j = 0; j < 3; j++) push_one(wrap_idx(j), j & 3, 1);
        for (int k = 0; k < 20; k++) begin
            set_push(wrap_idx(k + 3), (k + 3) & 3, 1);
            resolve_valid = 1'b1; resolve_taken = 1'b1;
            step();
            check($sformatf("t6_idx%0d", k), upd_idx, wrap_idx(k));
            check($sformatf("t6_sc%0d", k), upd_sc, k & 3);
        end
        check("t6_cnt", count, 3);
        check("t6_mis", mispredict, 0);

        // Reset right after a resolve cancels the pending update.
        idle_inputs();
        resolve_valid = 1'b1; resolve_taken = 1'b1;
        rst_n = 1'b0;
        step();
        idle_inputs();
        check_quiet("t6_rst");
        rst_n = 1'b1;
        step();
        check_quiet("t6_post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bp_update_queue.md
# bp_update_queue

In-order tracking queue between the fetch-side gshare predictor and the execute-stage branch unit. Each fetched conditional branch pushes its prediction record (PHT index, counter snapshot, predicted direction). When execute resolves the oldest branch, the queue pops that record and drives the predictor's update port with the actual outcome. It also raises a registered mispredict pulse and discards all younger, wrong-path records.

## Interface

Parameters:
- DEPTH, 8, number of in-flight branch records; power of two, ≥2.
- IDX_W, 5, PHT index width; equals log2 of the predictor SIZE (32).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- push_valid  in  1  fetch presents a branch prediction record.
- push_ready  out  1  queue can accept a record; equals !full.
- push_idx  in  IDX_W  PHT index from the predictor's predict_idx.
- push_sc  in  2  counter snapshot from predict_sc.
- push_taken  in  1  predicted direction from predict_taken.
- resolve_valid  in  1  execute resolved the oldest in-flight branch.
- resolve_taken  in  1  actual direction of that branch.
- flush  in  1  external pipeline flush (jump, trap); discards all records.
- upd_br_inst  out  1  update strobe to the predictor.
- upd_br_taken  out  1  actual outcome to the predictor.
- upd_idx  out  IDX_W  PHT index to update.
- upd_sc  out  2  counter snapshot; the predictor applies the saturating ±1.
- mispredict  out  1  one-cycle pulse: resolved direction ≠ stored prediction.
- resolve_err  out  1  one-cycle pulse: resolve_valid arrived while the queue was empty.
- count  out  log2(DEPTH)+1  number of valid records.

## Operation

- Circular buffer with head and tail pointers, log2(DEPTH) bits each, wrapping modulo DEPTH. An occupancy counter drives full (count==DEPTH) and empty (count==0).
- Push is accepted when push_valid && push_ready, and no drop condition below applies. The record is written at the tail, then tail increments.
- Resolve when not empty:
  - The head record is read and head increments.
  - Next cycle: upd_br_inst=1, upd_br_taken=resolve_taken, upd_idx and upd_sc come from the record.
  - mispredict = (resolve_taken != record.taken), asserted on the same cycle as upd_br_inst.
- Resolve when empty: no pop and no update. resolve_err pulses next cycle.
- Mispredicting resolve: after the pop, all remaining records are discarded (count→0, head=tail). A push in the same cycle is dropped.
- flush: all records are discarded and a push in the same cycle is dropped. A resolve in the same cycle is still processed first (oldest branch is architecturally committed), so its update and mispredict are still emitted.
- Push and resolve in the same cycle, no mispredict, no flush: both take effect and count is unchanged. push_ready depends only on current count, so no push is accepted when full, even with a concurrent pop.
- No bypass: a record pushed in cycle N is resolvable from cycle N+1.
- push_ready is combinational from count. All other outputs are registered.

## Timing

- Reset (rst_n=0 at an edge):
  - count=0, head=tail=0.
  - upd_br_inst=0, upd_br_taken=0, upd_idx=0, upd_sc=0, mispredict=0, resolve_err=0.
  - push_ready=1.
  - Storage contents are don't-care.
- Reset mid-operation discards all records. Any update pending from the prior cycle is cancelled; outputs read 0 on the cycle after the reset edge.
- Resolve accepted at edge N: upd_* and mispredict are valid for exactly the cycle following edge N, then return to 0 unless another resolve occurred.
- Back-to-back resolves give back-to-back update strobes, one per cycle.
- count reflects pushes, pops and discards one cycle after the edge.

## Test plan

- Reset then 3 pushes (idx 3/7/9, sc 1/2/3, taken 0/1/1), then 3 resolves (0,1,1) back-to-back:
  - update strobes on 3 consecutive cycles with idx 3,7,9 and sc 1,2,3.
  - mispredict never set; count 3→0.
- Fill to DEPTH=8:
  - push_ready=0 and a 9th push is ignored.
  - simultaneous push+resolve at full: push still ignored, count 8→7.
  - afterwards push_ready=1.
- Push 4 records, first with taken=0; resolve_taken=1 with a concurrent push:
  - next cycle mispredict=1, upd_br_taken=1.
  - count=0; concurrent push dropped.
- Push 2, assert flush together with resolve_valid (correct prediction):
  - update for the head record emitted, mispredict=0.
  - count=0.
- resolve_valid on an empty queue with a concurrent push:
  - resolve_err=1, upd_br_inst=0, count=1.
  - the pushed record is resolvable next cycle.
- 20 push/resolve pairs to wrap the pointers twice, then rst_n=0 mid-stream:
  - record order preserved across the wrap.
  - after reset, all outputs 0 and count=0.
